axi_llc_aw_master: RTL and testbench

Eviction address stage of the LLC eviction/refill path. Sits directly upstream of the eviction W-beat unit.

- Accepts a descriptor and, when its `evict` flag is set, issues one full-line AW burst on the AXI master port for the victim line.
- Forwards the descriptor downstream, so W beats are only generated for lines whose AW is already issued or being issued.
- The AW handshake and the descriptor handshake are independent forks of one registered descriptor.
- Non-evicting descriptors, including flush descriptors without `evict`, pass through with no AW.

---
 rtl/axi_llc_pkg.sv | 65 ++++++
 rtl/axi_llc_aw_master.sv | 94 +++++++++
 tb/tb_axi_llc_aw_master.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_llc_pkg.sv
// Shared LLC configuration types plus the example descriptor and AXI AW payload
// types used by the eviction address stage.
package axi_llc_pkg;

    typedef struct packed {
        int unsigned NumBlocks;
        int unsigned TagLength;
        int unsigned IndexLength;
        int unsigned BlockOffsetLength;
        int unsigned ByteOffsetLength;
    } llc_cfg_t;

    typedef struct packed {
        int unsigned AddrWidthFull;
        int unsigned DataWidthFull;
        int unsigned IdWidthMaster;
    } llc_axi_cfg_t;

    localparam llc_cfg_t LlcDefaultCfg = '{
        NumBlocks:         32'd4,
        TagLength:         32'd23,
        IndexLength:       32'd4,
        BlockOffsetLength: 32'd2,
        ByteOffsetLength:  32'd3
    };

    localparam llc_axi_cfg_t LlcAxiDefaultCfg = '{
        AddrWidthFull: 32'd32,
        DataWidthFull: 32'd64,
        IdWidthMaster: 32'd4
    };

    // Single ID for every eviction so B responses come back in AW order.
    localparam int unsigned EvictAwId    = 0;
    localparam logic [3:0]  EvictAwCache = 4'b0011;
    localparam logic [1:0]  AxiBurstIncr = 2'b01;

    localparam int unsigned DescTagW  = LlcDefaultCfg.TagLength;
    localparam int unsigned DescAddrW = LlcAxiDefaultCfg.AddrWidthFull;
    localparam int unsigned AwIdW     = LlcAxiDefaultCfg.IdWidthMaster;
    localparam int unsigned AwAddrW   = LlcAxiDefaultCfg.AddrWidthFull;

    typedef struct packed {
        logic                 evict;
        logic                 flush;
        logic [DescTagW-1:0]  evict_tag;
        logic [DescAddrW-1:0] a_x_addr;
    } llc_desc_t;

    typedef struct packed {
        logic [AwIdW-1:0]   id;
        logic [AwAddrW-1:0] addr;
        logic [7:0]         len;
        logic [2:0]         size;
        logic [1:0]         burst;
        logic               lock;
        logic [3:0]         cache;
        logic [2:0]         prot;
        logic [3:0]         qos;
        logic [3:0]         region;
        logic [5:0]         atop;
        logic               user;
    } llc_aw_chan_t;

endpackage

// File: rtl/axi_llc_aw_master.sv
// Eviction address stage: registers one descriptor, forks it into an AW burst
// for the victim line (when evicting) and a descriptor for the W-beat unit.
module axi_llc_aw_master
    import axi_llc_pkg::*;
#(
    parameter llc_cfg_t     Cfg       = LlcDefaultCfg,
    parameter llc_axi_cfg_t AxiCfg    = LlcAxiDefaultCfg,
    parameter type          desc_t    = llc_desc_t,
    parameter type          aw_chan_t = llc_aw_chan_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  desc_t    desc_i,
    input  logic     desc_valid_i,
    output logic     desc_ready_o,
    output desc_t    desc_o,
    output logic     desc_valid_o,
    input  logic     desc_ready_i,
    output aw_chan_t aw_chan_mst_o,
    output logic     aw_chan_valid_o,
    input  logic     aw_chan_ready_i
);

    localparam int unsigned TagW  = Cfg.TagLength;
    localparam int unsigned IdxW  = Cfg.IndexLength;
    localparam int unsigned OffW  = Cfg.BlockOffsetLength + Cfg.ByteOffsetLength;
    localparam int unsigned LineW = TagW + IdxW + OffW;
    localparam int unsigned AddrW = AxiCfg.AddrWidthFull;
    localparam int unsigned IdW   = AxiCfg.IdWidthMaster;

    desc_t              r_desc;
    logic               r_aw_pend;
    logic               r_desc_pend;
    logic               w_accept;
    logic               w_aw_hs;
    logic               w_desc_hs;
    logic [LineW-1:0]   w_line_addr;
    aw_chan_t           w_aw;

    // Fork-ready: free once every pending branch completes this cycle.
    assign desc_ready_o = (~r_aw_pend | aw_chan_ready_i) & (~r_desc_pend | desc_ready_i);
    assign w_accept     = desc_valid_i & desc_ready_o;
    assign w_aw_hs      = r_aw_pend & aw_chan_ready_i;
    assign w_desc_hs    = r_desc_pend & desc_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_pend   <= 1'b0;
            r_desc_pend <= 1'b0;
        end else if (w_accept) begin
            r_aw_pend   <= desc_i.evict;
            r_desc_pend <= 1'b1;
        end else begin
            if (w_aw_hs)   r_aw_pend   <= 1'b0;
            if (w_desc_hs) r_desc_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_desc <= '0;
        end else if (w_accept) begin
            r_desc <= desc_i;
        end
    end

    // Victim line address: stored tag, index from the request, line-aligned.
    assign w_line_addr = {TagW'(r_desc.evict_tag),
                          r_desc.a_x_addr[OffW +: IdxW],
                          OffW'(0)};

    always_comb begin
        w_aw       = '0;
        w_aw.id    = IdW'(EvictAwId);
        w_aw.addr  = AddrW'(w_line_addr);
        w_aw.len   = 8'(Cfg.NumBlocks - 1);
        w_aw.size  = 3'($clog2(AxiCfg.DataWidthFull / 8));
        w_aw.burst = AxiBurstIncr;
        w_aw.cache = EvictAwCache;
    end

    assign aw_chan_mst_o   = w_aw;
    assign aw_chan_valid_o = r_aw_pend;
    assign desc_o          = r_desc;
    assign desc_valid_o    = r_desc_pend;

`ifndef SYNTHESIS
    a_aw_evict : assert property (@(posedge clk_i) disable iff (!rst_ni)
        aw_chan_valid_o |-> r_desc.evict);
    a_aw_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (aw_chan_valid_o && !aw_chan_ready_i) |=> $stable(aw_chan_mst_o));
`endif

endmodule

// File: tb/tb_axi_llc_aw_master.sv
// Scoreboard bench for axi_llc_aw_master: stimulus pushes expected AW/descriptor
// items, a negedge monitor pops and compares them on every handshake.
module tb_axi_llc_aw_master;
    import axi_llc_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    llc_desc_t    desc_i;
    logic         desc_valid_i;
    logic         desc_ready_o;
    llc_desc_t    desc_o;
    logic         desc_valid_o;
    logic         desc_ready_i;
    llc_aw_chan_t aw_mst;
    logic         aw_valid;
    logic         aw_ready;

    int n_checks = 0;
    int n_errors = 0;
    int n_aw     = 0;
    int n_desc   = 0;

    llc_aw_chan_t exp_aw[$];
    llc_desc_t    exp_desc[$];

    always #5 clk = ~clk;

    axi_llc_aw_master #(
        .Cfg       (LlcDefaultCfg),
        .AxiCfg    (LlcAxiDefaultCfg),
        .desc_t    (llc_desc_t),
        .aw_chan_t (llc_aw_chan_t)
    ) u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .desc_i          (desc_i),
        .desc_valid_i    (desc_valid_i),
        .desc_ready_o    (desc_ready_o),
        .desc_o          (desc_o),
        .desc_valid_o    (desc_valid_o),
        .desc_ready_i    (desc_ready_i),
        .aw_chan_mst_o   (aw_mst),
        .aw_chan_valid_o (aw_valid),
        .aw_chan_ready_i (aw_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic llc_desc_t mk_desc(input logic ev, input logic fl,
                                          input logic [22:0] tag, input logic [31:0] ax);
        llc_desc_t d;
        d.evict     = ev;
        d.flush     = fl;
        d.evict_tag = tag;
        d.a_x_addr  = ax;
        return d;
    endfunction

    function automatic llc_aw_chan_t mk_aw(input logic [31:0] addr);
        llc_aw_chan_t a;
        a       = '0;
        a.addr  = addr;
        a.len   = 8'd3;
        a.size  = 3'd3;
        a.burst = 2'b01;
        a.cache = 4'b0011;
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a descriptor from posedge+1, wait for acceptance, register expectations.
    task automatic send(input llc_desc_t d, input logic [31:0] addr);
        int waited;
        desc_i       = d;
        desc_valid_i = 1'b1;
        waited       = 0;
        @(negedge clk);
        while (!desc_ready_o && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!desc_ready_o) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout actual=not_ready required=ready");
        end else begin
            exp_desc.push_back(d);
            if (d.evict) exp_aw.push_back(mk_aw(addr));
        end
        tick();
        desc_valid_i = 1'b0;
    endtask

    // Monitor: compare every handshake against the scoreboard; check AW stability.
    initial begin
        llc_aw_chan_t e_aw;
        llc_aw_chan_t aw_prev;
        llc_desc_t    e_d;
        logic         aw_stall;
        aw_stall = 1'b0;
        aw_prev  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_stall = 1'b0;
            end else begin
                if (aw_valid && aw_stall) begin
                    n_checks++;
                    if (aw_mst !== aw_prev) begin
                        n_errors++;
                        $display("FAIL aw_stable actual=%h required=%h", aw_mst, aw_prev);
                    end
                end
                if (aw_valid && aw_ready) begin
                    n_aw++;
                    n_checks++;
                    if (exp_aw.size() == 0) begin
                        n_errors++;
                        $display("FAIL aw_unexpected actual=%h required=none", aw_mst);
                    end else begin
                        e_aw = exp_aw.pop_front();
                        if (aw_mst !== e_aw) begin
                            n_errors++;
                            $display("FAIL aw_payload actual=%h required=%h", aw_mst, e_aw);
                        end
                    end
                end
                if (desc_valid_o && desc_ready_i) begin
                    n_desc++;
                    n_checks++;
                    if (exp_desc.size() == 0) begin
                        n_errors++;
                        $display("FAIL desc_unexpected actual=%h required=none", desc_o);
                    end else begin
                        e_d = exp_desc.pop_front();
                        if (desc_o !== e_d) begin
                            n_errors++;
                            $display("FAIL desc_payload actual=%h required=%h", desc_o, e_d);
                        end
                    end
                end
                aw_stall = aw_valid && !aw_ready;
                aw_prev  = aw_mst;
            end
        end
    end

    initial begin
        int a0;
        rst_n        = 1'b0;
        desc_i       = '0;
        desc_valid_i = 1'b0;
        desc_ready_i = 1'b0;
        aw_ready     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_aw_valid", 64'(aw_valid), 64'd0);
        check("rst_desc_valid", 64'(desc_valid_o), 64'd0);
        check("rst_desc_o", 64'(desc_o), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_desc_ready", 64'(desc_ready_o), 64'd1);
        tick();

        // Evict, both readies high: tag 0x1A, index 5 -> 0x34A0
        aw_ready     = 1'b1;
        desc_ready_i = 1'b1;
        send(mk_desc(1'b1, 1'b0, 23'h1A, 32'hABCD_E0BF), 32'h0000_34A0);
        @(negedge clk);
        check("t1_aw_valid", 64'(aw_valid), 64'd1);
        check("t1_desc_valid", 64'(desc_valid_o), 64'd1);
        check("t1_desc_ready", 64'(desc_ready_o), 64'd1);
        tick();

        // Non-evict stream at full rate: no AW, no bubble
        for (int i = 0; i < 4; i++) begin
            desc_i       = mk_desc(1'b0, 1'b0, 23'(i + 7), 32'(32'h100 * i + 5));
            desc_valid_i = 1'b1;
            @(negedge clk);
            if (i > 0) check("t2_stream_valid", 64'(desc_valid_o), 64'd1);
            check("t2_stream_ready", 64'(desc_ready_o), 64'd1);
            exp_desc.push_back(desc_i);
            tick();
        end
        desc_valid_i = 1'b0;
        @(negedge clk);
        check("t2_last_valid", 64'(desc_valid_o), 64'd1);
        check("t2_no_aw", 64'(aw_valid), 64'd0);
        tick();

        // AW stalled 5 cycles, desc side ready: tag 3, index 0 -> 0x600
        aw_ready = 1'b0;
        a0       = n_aw;
        send(mk_desc(1'b1, 1'b0, 23'h3, 32'h0000_001F), 32'h0000_0600);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_aw_valid", 64'(aw_valid), 64'd1);
            check("t3_desc_ready", 64'(desc_ready_o), 64'd0);
            check("t3_desc_valid", 64'(desc_valid_o), (c == 0) ? 64'd1 : 64'd0);
            tick();
        end
        aw_ready = 1'b1;
        @(negedge clk);
        check("t3_ready_on_hs", 64'(desc_ready_o), 64'd1);
        tick();
        check("t3_aw_count", 64'(n_aw - a0), 64'd1);

        // Reversed order: AW immediate, desc held 3 cycles: tag max, index F
        desc_ready_i = 1'b0;
        a0           = n_aw;
        send(mk_desc(1'b1, 1'b0, 23'h7F_FFFF, 32'h0000_01FF), 32'hFFFF_FFE0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t4_aw_valid", 64'(aw_valid), (c == 0) ? 64'd1 : 64'd0);
            check("t4_desc_held", 64'(desc_valid_o), 64'd1);
            check("t4_desc_ready", 64'(desc_ready_o), 64'd0);
            tick();
        end
        desc_ready_i = 1'b1;
        desc_i       = mk_desc(1'b0, 1'b0, 23'h55, 32'h0000_0020);
        desc_valid_i = 1'b1;
        @(negedge clk);
        check("t4_accept_on_ready", 64'(desc_ready_o), 64'd1);
        exp_desc.push_back(desc_i);
        tick();
        desc_valid_i = 1'b0;
        tick();
        check("t4_aw_count", 64'(n_aw - a0), 64'd1);

        // Flush without evict, then flush with evict: tag 0x12, index A -> 0x2540
        a0 = n_aw;
        send(mk_desc(1'b0, 1'b1, 23'h12, 32'h5555_5147), 32'h0);
        send(mk_desc(1'b1, 1'b1, 23'h12, 32'h5555_5147), 32'h0000_2540);
        repeat (2) tick();
        check("t5_aw_count", 64'(n_aw - a0), 64'd1);

        // Reset while both handshakes pending
        aw_ready     = 1'b0;
        desc_ready_i = 1'b0;
        send(mk_desc(1'b1, 1'b0, 23'h2A, 32'h0000_0060), 32'h0000_5460);
        @(negedge clk);
        check("t6_pre_aw_valid", 64'(aw_valid), 64'd1);
        check("t6_pre_desc_valid", 64'(desc_valid_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_aw_valid", 64'(aw_valid), 64'd0);
        check("t6_rst_desc_valid", 64'(desc_valid_o), 64'd0);
        exp_aw.delete();
        exp_desc.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_post_desc_ready", 64'(desc_ready_o), 64'd1);
        check("t6_post_aw_valid", 64'(aw_valid), 64'd0);
        check("t6_post_desc_valid", 64'(desc_valid_o), 64'd0);
        repeat (3) tick();

        check("end_exp_aw_empty", 64'(exp_aw.size()), 64'd0);
        check("end_exp_desc_empty", 64'(exp_desc.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
